// File: rtl/dmem_sync_pkg.sv
// Shared definitions for the dmem_sync data memory: XLEN, RV32I load/store
// funct3 codes, FSM state encoding and the illegal-funct3 predicate.
package dmem_sync_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Stores only have three legal widths; loads add the unsigned variants.
  function automatic logic illegal_funct3(input logic is_store, input logic [2:0] f3);
    if (is_store) return f3[2] | (f3 == 3'b011);
    return (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for dmem_sync: store byte-enables and
// replicated write data, load extraction/extension, and the misalign flag.
module dmem_lane_align
  import dmem_sync_pkg::*;
(
  input  logic [1:0]      addr_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [XLEN-1:0] word_i,
  output logic [3:0]      byte_en_o,
  output logic [XLEN-1:0] store_word_o,
  output logic [XLEN-1:0] load_data_o,
  output logic            misalign_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = word_i[8*addr_i +: 8];
  assign half_lane = addr_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    load_data_o = '0;
    case (funct3_i)
      F3_LB:   load_data_o = {{24{byte_lane[7]}}, byte_lane};
      F3_LH:   load_data_o = {{16{half_lane[15]}}, half_lane};
      F3_LW:   load_data_o = word_i;
      F3_LBU:  load_data_o = {24'h0, byte_lane};
      F3_LHU:  load_data_o = {16'h0, half_lane};
      default: load_data_o = '0;
    endcase
  end

  // Write data is replicated across lanes so the byte-enable alone selects it.
  always_comb begin
    byte_en_o    = 4'b0000;
    store_word_o = '0;
    case (funct3_i)
      F3_SB: begin
        byte_en_o    = 4'b0001 << addr_i;
        store_word_o = {4{store_data_i[7:0]}};
      end
      F3_SH: begin
        byte_en_o    = addr_i[1] ? 4'b1100 : 4'b0011;
        store_word_o = {2{store_data_i[15:0]}};
      end
      F3_SW: begin
        byte_en_o    = 4'b1111;
        store_word_o = store_data_i;
      end
      default: begin
        byte_en_o    = 4'b0000;
        store_word_o = '0;
      end
    endcase
  end

  assign misalign_o = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                      ((funct3_i[1:0] == 2'b10) && (addr_i != 2'b00));

endmodule

// File: rtl/dmem_sync.sv
// Synchronous RV32I data memory with req/ack handshake and WAIT_STATES latency.
// Define DMEM_ERR_CHECK_EN to flag misaligned, out-of-range and illegal accesses.
module dmem_sync
  import dmem_sync_pkg::*;
#(
  parameter int    DEPTH       = 1024,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_mem_req,
  input  logic [XLEN-1:0] i_mem_addr,
  input  logic [XLEN-1:0] i_mem_data,
  input  logic [2:0]      i_funct3,
  input  logic            i_read_write,
  output logic            or_mem_ack,
  output logic [XLEN-1:0] or_mem_data,
  output logic            or_mem_err,
  output logic            or_mem_busy
);

  localparam int         ADDR_W = $clog2(DEPTH);
  localparam logic [3:0] WS     = WAIT_STATES[3:0];

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   data_q;
  logic [2:0]        funct3_q;
  logic              rw_q;
  logic              ack_q;
  logic              err_q;
  logic              busy_q;
  logic [XLEN-1:0]   rdata_q;
  logic [XLEN-1:0]   mem_q [DEPTH];

  logic [XLEN-1:0]   cur_addr;
  logic [XLEN-1:0]   cur_data;
  logic [2:0]        cur_funct3;
  logic              cur_rw;
  logic [ADDR_W-1:0] word_idx;
  logic [3:0]        byte_en;
  logic [XLEN-1:0]   store_word;
  logic [XLEN-1:0]   load_data;
  logic              misalign;
  logic              access_err;
  logic              enter_resp;
  logic              wr_en;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] = '0;
  end

  // With zero wait states RESP is entered on the accept edge itself, so the
  // access is steered from the live inputs in IDLE and from the captures later.
  assign cur_addr   = (state_q == ST_IDLE) ? i_mem_addr   : addr_q;
  assign cur_data   = (state_q == ST_IDLE) ? i_mem_data   : data_q;
  assign cur_funct3 = (state_q == ST_IDLE) ? i_funct3     : funct3_q;
  assign cur_rw     = (state_q == ST_IDLE) ? i_read_write : rw_q;
  assign word_idx   = cur_addr[ADDR_W+1:2];

  dmem_lane_align u_lane_align (
    .addr_i       (cur_addr[1:0]),
    .funct3_i     (cur_funct3),
    .store_data_i (cur_data),
    .word_i       (mem_q[word_idx]),
    .byte_en_o    (byte_en),
    .store_word_o (store_word),
    .load_data_o  (load_data),
    .misalign_o   (misalign)
  );

`ifdef DMEM_ERR_CHECK_EN
  assign access_err = misalign
                    | (cur_addr[XLEN-1:ADDR_W+2] != '0)
                    | illegal_funct3(cur_rw, cur_funct3);
`else
  logic unused_ok;
  assign unused_ok  = ^{misalign, cur_addr[XLEN-1:ADDR_W+2]};
  assign access_err = 1'b0;
`endif

  assign enter_resp = ((state_q == ST_IDLE) && i_mem_req && (WS == 4'd0)) ||
                      ((state_q == ST_WAIT) && (cnt_q == 4'd1));

  assign wr_en = enter_resp && cur_rw && !access_err && i_rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      funct3_q <= '0;
      rw_q     <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_mem_req) begin
            addr_q   <= i_mem_addr;
            data_q   <= i_mem_data;
            funct3_q <= i_funct3;
            rw_q     <= i_read_write;
            cnt_q    <= WS;
            busy_q   <= 1'b1;
            state_q  <= (WS == 4'd0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= ST_RESP;
        end
        ST_RESP: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      ack_q <= enter_resp;
      err_q <= enter_resp && access_err;
      if (enter_resp && !cur_rw && !access_err) rdata_q <= load_data;
    end
  end

  // The array is deliberately outside the reset domain.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_q[word_idx][8*b +: 8] <= store_word[8*b +: 8];
      end
    end
  end

  assign or_mem_ack  = ack_q;
  assign or_mem_err  = err_q;
  assign or_mem_busy = busy_q;
  assign or_mem_data = rdata_q;

endmodule

// File: tb/tb_dmem_sync.sv
// Self-checking bench for dmem_sync: three instances (0, 3 and 5 wait states)
// against a byte-array reference model; honours DMEM_ERR_CHECK_EN.
module tb_dmem_sync;

  localparam int DEPTH = 64;
  localparam int BA_W  = $clog2(4 * DEPTH);

  logic        clk;
  logic        rst_n   [3];
  logic        req     [3];
  logic [31:0] addr    [3];
  logic [31:0] wdata   [3];
  logic [2:0]  f3      [3];
  logic        rw      [3];
  logic        ack     [3];
  logic        err     [3];
  logic        busy    [3];
  logic [31:0] rdata   [3];

  logic [7:0]  mbytes  [3][4*DEPTH];
  logic [31:0] expRd   [3];

  int vecCount  = 0;
  int missCount = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_sync #(
      .DEPTH       (DEPTH),
      .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 3 : 5)),
      .INIT_FILE   ("")
    ) u_dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n[g]),
      .i_mem_req    (req[g]),
      .i_mem_addr   (addr[g]),
      .i_mem_data   (wdata[g]),
      .i_funct3     (f3[g]),
      .i_read_write (rw[g]),
      .or_mem_ack   (ack[g]),
      .or_mem_data  (rdata[g]),
      .or_mem_err   (err[g]),
      .or_mem_busy  (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wsOf(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 5);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: an access faults only when error checking is built in.
  function automatic bit modelErr(input bit isStore, input logic [2:0] fn, input logic [31:0] a);
`ifdef DMEM_ERR_CHECK_EN
    bit bad;
    bad = isStore ? (fn > 3'd2) : (fn == 3'd3 || fn == 3'd6 || fn == 3'd7);
    if (fn[1:0] == 2'd1 && a % 2 != 0) bad = 1'b1;
    if (fn[1:0] == 2'd2 && a % 4 != 0) bad = 1'b1;
    if (a >= 32'(4 * DEPTH)) bad = 1'b1;
    return bad;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] modelLoad(input int k, input logic [2:0] fn, input logic [31:0] a);
    int unsigned base;
    logic [7:0]  b;
    logic [15:0] h;
    base = 32'(a[BA_W-1:0]);
    case (fn)
      3'd0, 3'd4: begin
        b = mbytes[k][base];
        return fn[2] ? {24'h0, b} : {{24{b[7]}}, b};
      end
      3'd1, 3'd5: begin
        base = base - base % 2;
        h = {mbytes[k][base+1], mbytes[k][base]};
        return fn[2] ? {16'h0, h} : {{16{h[15]}}, h};
      end
      3'd2: begin
        base = base - base % 4;
        return {mbytes[k][base+3], mbytes[k][base+2], mbytes[k][base+1], mbytes[k][base]};
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic void modelStore(input int k, input logic [2:0] fn, input logic [31:0] a,
                                     input logic [31:0] d);
    int unsigned base;
    base = 32'(a[BA_W-1:0]);
    case (fn)
      3'd0: mbytes[k][base] = d[7:0];
      3'd1: begin
        base = base - base % 2;
        mbytes[k][base]   = d[7:0];
        mbytes[k][base+1] = d[15:8];
      end
      3'd2: begin
        base = base - base % 4;
        for (int i = 0; i < 4; i++) mbytes[k][base+i] = d[8*i +: 8];
      end
      default: ;
    endcase
  endfunction

  // One full handshake: accept, bounded wait for ack, then check everything.
  task automatic applyStimulus(input int k, input bit isStore, input logic [2:0] fn,
                               input logic [31:0] a, input logic [31:0] d, input bit poke);
    int          lat;
    bit          e;
    logic [31:0] expData;
    e = modelErr(isStore, fn, a);
    expData = expRd[k];
    if (!isStore && !e) expData = modelLoad(k, fn, a);
    @(negedge clk);
    checkOutput($sformatf("idle_busy_k%0d", k), 32'(busy[k]), 32'd0);
    req[k] = 1'b1; addr[k] = a; wdata[k] = d; f3[k] = fn; rw[k] = isStore;
    @(negedge clk);
    req[k] = 1'b0; addr[k] = $urandom; wdata[k] = $urandom;
    f3[k] = 3'($urandom); rw[k] = 1'($urandom);
    lat = 1;
    while (ack[k] !== 1'b1 && lat <= 40) begin
      checkOutput($sformatf("wait_busy_k%0d", k), 32'(busy[k]), 32'd1);
      if (poke && lat == 2) begin
        req[k] = 1'b1; addr[k] = 32'h20; wdata[k] = 32'hFFFF_FFFF; f3[k] = 3'd2; rw[k] = 1'b1;
      end else begin
        req[k] = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    req[k] = 1'b0;
    checkOutput($sformatf("latency_k%0d", k), 32'(lat), 32'(wsOf(k) + 1));
    checkOutput($sformatf("ack_busy_k%0d", k), 32'(busy[k]), 32'd1);
    checkOutput($sformatf("err_k%0d_a%08h", k, a), 32'(err[k]), 32'(e));
    checkOutput($sformatf("data_k%0d_a%08h_f%0d", k, a, fn), rdata[k], expData);
    @(negedge clk);
    checkOutput($sformatf("ack_drop_k%0d", k), 32'(ack[k]), 32'd0);
    checkOutput($sformatf("busy_drop_k%0d", k), 32'(busy[k]), 32'd0);
    if (isStore && !e) modelStore(k, fn, a, d);
    expRd[k] = expData;
  endtask

  task automatic randomAccess(input int k);
    bit          isStore;
    logic [2:0]  fn;
    logic [31:0] a;
    int          r;
    isStore = 1'($urandom);
    r = $urandom_range(0, 9);
    if (r == 0) fn = 3'($urandom);
    else if (isStore) fn = 3'($urandom_range(0, 2));
    else begin
      case ($urandom_range(0, 4))
        0: fn = 3'd0; 1: fn = 3'd1; 2: fn = 3'd2; 3: fn = 3'd4; default: fn = 3'd5;
      endcase
    end
    r = $urandom_range(0, 9);
    if (r == 0) a = $urandom;
    else if (r == 1) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
    else a = 32'($urandom_range(0, 4 * DEPTH - 1));
    if ($urandom_range(0, 4) != 0) begin
      if (fn[1:0] == 2'd1) a = a - a % 2;
      if (fn[1:0] == 2'd2) a = a - a % 4;
    end
    applyStimulus(k, isStore, fn, a, $urandom, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; req[k] = 1'b0; addr[k] = '0; wdata[k] = '0; f3[k] = '0; rw[k] = 1'b0;
      expRd[k] = '0;
      for (int i = 0; i < 4 * DEPTH; i++) mbytes[k][i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("rst_ack_k%0d", k), 32'(ack[k]), 32'd0);
      checkOutput($sformatf("rst_err_k%0d", k), 32'(err[k]), 32'd0);
      checkOutput($sformatf("rst_busy_k%0d", k), 32'(busy[k]), 32'd0);
      checkOutput($sformatf("rst_data_k%0d", k), rdata[k], 32'd0);
      rst_n[k] = 1'b1;
    end

    // Store/load round trip with zero wait states.
    applyStimulus(0, 1'b1, 3'd2, 32'h80, 32'h8765_4321, 1'b0);
    applyStimulus(0, 1'b0, 3'd0, 32'h83, 32'h0, 1'b0);
    checkOutput("lb_0x83", rdata[0], 32'hFFFF_FF87);
    applyStimulus(0, 1'b0, 3'd4, 32'h83, 32'h0, 1'b0);
    checkOutput("lbu_0x83", rdata[0], 32'h0000_0087);

    // Halfword merged over an existing word.
    applyStimulus(0, 1'b1, 3'd2, 32'h40, 32'h1122_3344, 1'b0);
    applyStimulus(0, 1'b1, 3'd1, 32'h42, 32'h0000_A5A5, 1'b0);
    applyStimulus(0, 1'b0, 3'd2, 32'h40, 32'h0, 1'b0);
    checkOutput("lw_merge", rdata[0], 32'hA5A5_3344);
    applyStimulus(0, 1'b0, 3'd5, 32'h42, 32'h0, 1'b0);
    checkOutput("lhu_merge", rdata[0], 32'h0000_A5A5);

    // Out-of-range store and misaligned word load.
    applyStimulus(0, 1'b1, 3'd2, 32'h0, 32'h0BAD_F00D, 1'b0);
    applyStimulus(0, 1'b1, 3'd2, 32'(4 * DEPTH), 32'hCAFE_BABE, 1'b0);
    applyStimulus(0, 1'b0, 3'd2, 32'h0, 32'h0, 1'b0);
`ifdef DMEM_ERR_CHECK_EN
    checkOutput("word0_after_oor", rdata[0], 32'h0BAD_F00D);
`else
    checkOutput("word0_after_oor", rdata[0], 32'hCAFE_BABE);
`endif
    applyStimulus(0, 1'b0, 3'd4, 32'h81, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 3'd2, 32'h2, 32'h0, 1'b0);

    // Reset while a store sits in WAIT: it must never commit or ack.
    applyStimulus(1, 1'b1, 3'd2, 32'h10, 32'h0000_0000, 1'b0);
    @(negedge clk);
    req[1] = 1'b1; addr[1] = 32'h10; wdata[1] = 32'hDEAD_BEEF; f3[1] = 3'd2; rw[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    checkOutput("midstore_busy", 32'(busy[1]), 32'd1);
    #2 rst_n[1] = 1'b0;
    @(negedge clk);
    checkOutput("midstore_rst_busy", 32'(busy[1]), 32'd0);
    checkOutput("midstore_rst_ack", 32'(ack[1]), 32'd0);
    rst_n[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("midstore_no_ack", 32'(ack[1]), 32'd0);
    end
    expRd[1] = 32'h0;
    applyStimulus(1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
    checkOutput("midstore_lw", rdata[1], 32'h0);

    // Five wait states, with a stray request poked in during WAIT.
    applyStimulus(2, 1'b1, 3'd2, 32'h30, 32'h5555_AAAA, 1'b1);
    applyStimulus(2, 1'b0, 3'd2, 32'h20, 32'h0, 1'b0);
    checkOutput("poke_ignored", rdata[2], 32'h0);
    applyStimulus(2, 1'b0, 3'd2, 32'h30, 32'h0, 1'b0);
    checkOutput("ws5_readback", rdata[2], 32'h5555_AAAA);

    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < 3; k++) randomAccess(k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
